// File: rtl/cpu_lut_slave.sv
// CPU-accessible configuration look-up table with a one-shot cell-path lookup port.
// CPU and lookup share one table port; the CPU owns it only in the ACCESS cycle.
package cpu_lut_slave_pkg;
    typedef struct packed {
        logic [3:0]  fwd;
        logic [11:0] vpi;
    } cell_cfg_t;
endpackage

module cpu_lut_slave
    import cpu_lut_slave_pkg::*;
#(
    parameter int NUM_ENTRIES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BusMode,
    input  logic [11:0] Addr,
    input  logic        Sel,
    input  cell_cfg_t   DataIn,
    input  logic        Rd_DS,
    input  logic        Wr_RW,
    output cell_cfg_t   DataOut,
    output logic        Rdy_Dtack,
    input  logic        lk_req,
    input  logic [11:0] lk_vpi,
    output logic        lk_ack,
    output cell_cfg_t   lk_cfg,
    output logic        lk_hit
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t           state_reg, state_next;
    logic             mode_reg;
    logic             wr_reg;
    logic [11:0]      addr_reg;
    cell_cfg_t        din_reg;
    logic [NUM_ENTRIES-1:0] valid_reg;
    logic             cpu_hit_reg;
    logic             lk_ack_reg;
    logic             lk_hit_reg;
    cell_cfg_t        cpu_data_reg;
    cell_cfg_t        lk_data_reg;
    cell_cfg_t        mem [NUM_ENTRIES];

    logic             access_start;
    logic             strobe_held;
    logic             lk_grant;

    // In separate-strobe mode both strobes low at once is not a valid cycle, hence the XOR.
    always_comb begin
        access_start = !Sel && (BusMode ? (Rd_DS ^ Wr_RW) : !Rd_DS);
        strobe_held  = !Sel && ((mode_reg && wr_reg) ? !Wr_RW : !Rd_DS);
        lk_grant     = lk_req && (state_reg != ACCESS) && !lk_ack_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (access_start) state_next = ACCESS;
            ACCESS:  state_next = ACK;
            ACK:     if (!strobe_held) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mode_reg    <= 1'b0;
            wr_reg      <= 1'b0;
            addr_reg    <= '0;
            din_reg     <= '0;
            valid_reg   <= '0;
            cpu_hit_reg <= 1'b0;
            lk_ack_reg  <= 1'b0;
            lk_hit_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && access_start) begin
                mode_reg <= BusMode;
                wr_reg   <= !Wr_RW;
                addr_reg <= Addr;
                din_reg  <= DataIn;
            end
            if (state_reg == ACCESS) begin
                if (wr_reg) begin
                    valid_reg[addr_reg] <= 1'b1;
                    cpu_hit_reg         <= 1'b0;
                end else begin
                    cpu_hit_reg <= valid_reg[addr_reg];
                end
            end
            lk_ack_reg <= lk_grant;
            if (lk_grant) lk_hit_reg <= valid_reg[lk_vpi];
        end
    end

    // Table storage is never reset; the valid bits alone decide hit/miss.
    always_ff @(posedge clk) begin
        if (state_reg == ACCESS) begin
            if (wr_reg) mem[addr_reg] <= din_reg;
            else        cpu_data_reg  <= mem[addr_reg];
        end else if (lk_grant) begin
            lk_data_reg <= mem[lk_vpi];
        end
    end

    always_comb begin
        Rdy_Dtack = (state_reg != ACK);
        DataOut   = (state_reg == ACK && cpu_hit_reg) ? cpu_data_reg : '0;
        lk_ack    = lk_ack_reg;
        lk_hit    = lk_ack_reg && lk_hit_reg;
        lk_cfg    = (lk_ack_reg && lk_hit_reg) ? lk_data_reg : '0;
    end

endmodule

// File: tb/tb_cpu_lut_slave.sv
// Randomized self-checking bench for cpu_lut_slave against an array-based table model.
module tb_cpu_lut_slave;
    import cpu_lut_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        BusMode = 1'b1;
    logic [11:0] Addr = '0;
    logic        Sel = 1'b1;
    cell_cfg_t   DataIn = '0;
    logic        Rd_DS = 1'b1;
    logic        Wr_RW = 1'b1;
    cell_cfg_t   DataOut;
    logic        Rdy_Dtack;
    logic        lk_req = 1'b0;
    logic [11:0] lk_vpi = '0;
    logic        lk_ack;
    cell_cfg_t   lk_cfg;
    logic        lk_hit;

    int total = 0;
    int bad = 0;

    cell_cfg_t ref_mem [4096];
    bit        ref_valid [4096];

    always #5 clk = ~clk;

    cpu_lut_slave #(.NUM_ENTRIES(4096)) dut (
        .clk(clk), .rst_n(rst_n), .BusMode(BusMode), .Addr(Addr), .Sel(Sel),
        .DataIn(DataIn), .Rd_DS(Rd_DS), .Wr_RW(Wr_RW), .DataOut(DataOut),
        .Rdy_Dtack(Rdy_Dtack), .lk_req(lk_req), .lk_vpi(lk_vpi), .lk_ack(lk_ack),
        .lk_cfg(lk_cfg), .lk_hit(lk_hit)
    );

    function automatic cell_cfg_t ref_read(input logic [11:0] a);
        return ref_valid[a] ? ref_mem[a] : cell_cfg_t'(16'h0000);
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < 4096; i++) ref_valid[i] = 1'b0;
    endfunction

    // Runs one complete CPU cycle; the strobe is held two extra cycles in ACK before release.
    task automatic cpu_access(input logic mode, input logic wr, input logic [11:0] a,
                              input cell_cfg_t d, output cell_cfg_t rd, output int lat,
                              output logic held_ok, output logic rel_ok);
        @(posedge clk); #1;
        BusMode = mode; Addr = a; DataIn = d; Sel = 1'b0;
        if (mode) begin Rd_DS = wr; Wr_RW = !wr; end
        else begin Rd_DS = 1'b0; Wr_RW = !wr; end
        lat = 0;
        while (lat < 8) begin
            @(posedge clk); lat++; #1;
            if (Rdy_Dtack == 1'b0) break;
        end
        rd = DataOut;
        repeat (2) @(posedge clk);
        #1 held_ok = (Rdy_Dtack == 1'b0) && (DataOut == rd);
        Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
        @(posedge clk); #1;
        rel_ok = (Rdy_Dtack == 1'b1) && (DataOut == cell_cfg_t'(16'h0000));
    endtask

    task automatic do_lookup(input logic [11:0] v, output int lat, output logic hit,
                             output cell_cfg_t cfg, output logic single);
        @(posedge clk); #1;
        lk_req = 1'b1; lk_vpi = v;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk); lat++; #1;
            if (lk_ack) break;
        end
        hit = lk_hit; cfg = lk_cfg; lk_req = 1'b0;
        @(posedge clk); #1;
        single = !lk_ack;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++; if (Rdy_Dtack !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", Rdy_Dtack); end
        total++; if (DataOut !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0000", DataOut); end
        total++; if ({lk_ack, lk_hit} !== 2'b00 || lk_cfg !== 16'h0) begin
            bad++; $display("FAIL reset_lk got ack=%b hit=%b cfg=%h exp 0/0/0000", lk_ack, lk_hit, lk_cfg);
        end
        ref_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("reset applied and released");
    endtask

    task automatic test_lookup_miss();
        int lat; logic hit, single; cell_cfg_t cfg;
        do_lookup(12'h005, lat, hit, cfg, single);
        $display("lookup 005 lat=%0d hit=%b cfg=%h", lat, hit, cfg);
        total++; if (lat != 1) begin bad++; $display("FAIL miss_latency got=%0d exp=1", lat); end
        total++; if (hit !== 1'b0 || cfg !== 16'h0) begin bad++; $display("FAIL miss_value got hit=%b cfg=%h exp 0/0000", hit, cfg); end
        total++; if (single !== 1'b1) begin bad++; $display("FAIL miss_pulse got ack_next=%b exp=0", !single); end
    endtask

    task automatic test_write_read();
        int lat; logic held, rel; cell_cfg_t rd, d, exp;
        d = cell_cfg_t'({4'b0101, 12'h0A5});
        cpu_access(1'b1, 1'b1, 12'h005, d, rd, lat, held, rel);
        ref_mem[12'h005] = d; ref_valid[12'h005] = 1'b1;
        $display("write mode1 addr=005 data=%h lat=%0d", d, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL wr_ack_latency got=%0d exp=2", lat); end
        total++; if (held !== 1'b1 || rel !== 1'b1) begin bad++; $display("FAIL wr_hold_release got held=%b rel=%b exp 1/1", held, rel); end
        exp = ref_read(12'h005);
        cpu_access(1'b1, 1'b0, 12'h005, '0, rd, lat, held, rel);
        $display("read mode1 addr=005 data=%h lat=%0d", rd, lat);
        total++; if (rd !== exp || lat != 2) begin bad++; $display("FAIL rd_value got=%h lat=%0d exp=%h lat=2", rd, lat, exp); end
        total++; if (held !== 1'b1 || rel !== 1'b1) begin bad++; $display("FAIL rd_hold_release got held=%b rel=%b exp 1/1", held, rel); end
    endtask

    task automatic test_lookup_hit();
        int lat; logic hit, single; cell_cfg_t cfg;
        do_lookup(12'h005, lat, hit, cfg, single);
        $display("lookup 005 lat=%0d hit=%b cfg=%h", lat, hit, cfg);
        total++; if (lat != 1 || hit !== 1'b1 || cfg !== ref_read(12'h005)) begin
            bad++; $display("FAIL hit_value got lat=%0d hit=%b cfg=%h exp 1/1/%h", lat, hit, cfg, ref_read(12'h005));
        end
    endtask

    task automatic test_busmode0();
        int lat; logic held, rel; cell_cfg_t rd, d;
        d = cell_cfg_t'(16'($urandom));
        cpu_access(1'b0, 1'b1, 12'hFFF, d, rd, lat, held, rel);
        ref_mem[12'hFFF] = d; ref_valid[12'hFFF] = 1'b1;
        $display("write mode0 addr=fff data=%h lat=%0d", d, lat);
        total++; if (lat != 2 || rel !== 1'b1) begin bad++; $display("FAIL m0_write got lat=%0d rel=%b exp 2/1", lat, rel); end
        cpu_access(1'b0, 1'b0, 12'hFFF, '0, rd, lat, held, rel);
        $display("read mode0 addr=fff data=%h lat=%0d", rd, lat);
        total++; if (rd !== ref_read(12'hFFF) || held !== 1'b1 || rel !== 1'b1) begin
            bad++; $display("FAIL m0_read got=%h held=%b rel=%b exp=%h 1/1", rd, held, rel, ref_read(12'hFFF));
        end
    endtask

    task automatic test_both_strobes();
        int low_cycles; int lat; logic held, rel; cell_cfg_t rd;
        @(posedge clk); #1;
        BusMode = 1'b1; Addr = 12'hFFF; DataIn = ~ref_read(12'hFFF); Sel = 1'b0; Rd_DS = 1'b0; Wr_RW = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (Rdy_Dtack == 1'b0) low_cycles++;
        end
        Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
        $display("both strobes low for 4 cycles, ack cycles=%0d", low_cycles);
        total++; if (low_cycles != 0) begin bad++; $display("FAIL both_strobes_ack got=%0d exp=0", low_cycles); end
        cpu_access(1'b1, 1'b0, 12'hFFF, '0, rd, lat, held, rel);
        total++; if (rd !== ref_read(12'hFFF)) begin bad++; $display("FAIL both_strobes_nowrite got=%h exp=%h", rd, ref_read(12'hFFF)); end
    endtask

    task automatic test_conflict();
        @(posedge clk); #1;
        BusMode = 1'b1; Addr = 12'h005; Sel = 1'b0; Rd_DS = 1'b0; Wr_RW = 1'b1;
        @(posedge clk); #1;
        lk_req = 1'b1; lk_vpi = 12'hFFF;
        @(posedge clk); #1;
        total++; if (Rdy_Dtack !== 1'b0 || DataOut !== ref_read(12'h005) || lk_ack !== 1'b0) begin
            bad++; $display("FAIL conflict_cpu got rdy=%b dout=%h lk_ack=%b exp 0/%h/0", Rdy_Dtack, DataOut, lk_ack, ref_read(12'h005));
        end
        @(posedge clk); #1;
        total++; if (lk_ack !== 1'b1 || lk_hit !== 1'b1 || lk_cfg !== ref_read(12'hFFF)) begin
            bad++; $display("FAIL conflict_lookup got ack=%b hit=%b cfg=%h exp 1/1/%h", lk_ack, lk_hit, lk_cfg, ref_read(12'hFFF));
        end
        lk_req = 1'b0; Sel = 1'b1; Rd_DS = 1'b1;
        @(posedge clk); #1;
        total++; if (Rdy_Dtack !== 1'b1 || lk_ack !== 1'b0) begin
            bad++; $display("FAIL conflict_end got rdy=%b lk_ack=%b exp 1/0", Rdy_Dtack, lk_ack);
        end
        $display("conflict lookup fff during cpu read 005 done");
    endtask

    task automatic test_held_request();
        logic prev_ack; logic exp_ack; int mism;
        mism = 0; prev_ack = 1'b0;
        @(posedge clk); #1;
        lk_req = 1'b1; lk_vpi = 12'h005;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            exp_ack = !prev_ack;
            if (lk_ack !== exp_ack || (lk_ack && lk_cfg !== ref_read(12'h005))) mism++;
            prev_ack = exp_ack;
        end
        lk_req = 1'b0;
        @(posedge clk); #1;
        if (lk_ack !== 1'b0) mism++;
        $display("held lookup 005 for 5 cycles, pattern errors=%0d", mism);
        total++; if (mism != 0) begin bad++; $display("FAIL held_pattern got errors=%0d exp=0", mism); end
    endtask

    task automatic test_random();
        int op, lat; logic held, rel, hit, single; logic [11:0] a; cell_cfg_t d, rd, exp;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            a = 12'($urandom_range(0, 15)) | (($urandom_range(0, 1) != 0) ? 12'hF00 : 12'h000);
            d = cell_cfg_t'(16'($urandom));
            if (op == 0) begin
                cpu_access(1'($urandom_range(0, 1)), 1'b1, a, d, rd, lat, held, rel);
                ref_mem[a] = d; ref_valid[a] = 1'b1;
                $display("txn %0d write addr=%h data=%h lat=%0d", n, a, d, lat);
                total++; if (lat != 2 || held !== 1'b1 || rel !== 1'b1) begin
                    bad++; $display("FAIL rnd_write addr=%h got lat=%0d held=%b rel=%b exp 2/1/1", a, lat, held, rel);
                end
            end else if (op == 1) begin
                exp = ref_read(a);
                cpu_access(1'($urandom_range(0, 1)), 1'b0, a, d, rd, lat, held, rel);
                $display("txn %0d read addr=%h data=%h lat=%0d", n, a, rd, lat);
                total++; if (rd !== exp || lat != 2 || rel !== 1'b1) begin
                    bad++; $display("FAIL rnd_read addr=%h got=%h lat=%0d exp=%h lat=2", a, rd, lat, exp);
                end
            end else begin
                exp = ref_read(a);
                do_lookup(a, lat, hit, rd, single);
                $display("txn %0d lookup addr=%h hit=%b cfg=%h lat=%0d", n, a, hit, rd, lat);
                total++; if (lat != 1 || hit !== 1'(ref_valid[a]) || rd !== exp || single !== 1'b1) begin
                    bad++; $display("FAIL rnd_lookup addr=%h got lat=%0d hit=%b cfg=%h exp 1/%b/%h", a, lat, hit, rd, ref_valid[a], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic held, rel, hit, single; cell_cfg_t rd;
        @(posedge clk); #1;
        BusMode = 1'b1; Addr = 12'h123; DataIn = cell_cfg_t'(16'h5A5A); Sel = 1'b0; Rd_DS = 1'b1; Wr_RW = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (Rdy_Dtack !== 1'b1 || DataOut !== 16'h0) begin
            bad++; $display("FAIL midrst_outputs got rdy=%b dout=%h exp 1/0000", Rdy_Dtack, DataOut);
        end
        @(posedge clk); #1;
        Sel = 1'b1; Rd_DS = 1'b1; Wr_RW = 1'b1;
        rst_n = 1'b1;
        ref_clear();
        $display("reset pulled during write to 123");
        @(posedge clk); #1;
        total++; if (Rdy_Dtack !== 1'b1) begin bad++; $display("FAIL midrst_idle got rdy=%b exp=1", Rdy_Dtack); end
        cpu_access(1'b1, 1'b0, 12'h123, '0, rd, lat, held, rel);
        total++; if (rd !== ref_read(12'h123) || lat != 2) begin
            bad++; $display("FAIL midrst_read123 got=%h lat=%0d exp=%h lat=2", rd, lat, ref_read(12'h123));
        end
        cpu_access(1'b0, 1'b0, 12'h005, '0, rd, lat, held, rel);
        total++; if (rd !== ref_read(12'h005)) begin bad++; $display("FAIL midrst_read005 got=%h exp=%h", rd, ref_read(12'h005)); end
        do_lookup(12'h005, lat, hit, rd, single);
        total++; if (hit !== 1'b0 || rd !== 16'h0 || lat != 1) begin
            bad++; $display("FAIL midrst_lookup got hit=%b cfg=%h lat=%0d exp 0/0000/1", hit, rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_lookup_miss();
        test_write_read();
        test_lookup_hit();
        test_busmode0();
        test_both_strobes();
        test_conflict();
        test_held_request();
        test_random();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_lut_slave.md
CPU_LUT_SLAVE -- requirements
Module: cpu_lut_slave

Interface
REQ-001 Parameter: NUM_ENTRIES, default 4096, number of look-up table entries, indexed by the 12-bit VPI/Addr.
REQ-002 clk  input  1  single clock; every register is updated on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 BusMode  input  1  bus cycle type: 1 = separate read/write strobes; 0 = data strobe plus read/write select.
REQ-005 Addr  input  12  CPU table index.
REQ-006 Sel  input  1  chip select, active-low.
REQ-007 DataIn  input  CellCfgType  write data from the CPU (fields FWD, VPI).
REQ-008 Rd_DS  input  1  read strobe (BusMode=1) or data strobe (BusMode=0), active-low.
REQ-009 Wr_RW  input  1  write strobe (BusMode=1) or read/write select (BusMode=0; 0 = write).
REQ-010 DataOut  output  CellCfgType  read data to the CPU.
REQ-011 Rdy_Dtack  output  1  access acknowledge, active-low.
REQ-012 lk_req  input  1  cell-path lookup request; held high with lk_vpi stable until lk_ack.
REQ-013 lk_vpi  input  12  lookup index.
REQ-014 lk_ack  output  1  one-cycle pulse; lk_cfg and lk_hit are valid in that cycle.
REQ-015 lk_cfg  output  CellCfgType  looked-up entry.
REQ-016 lk_hit  output  1  1 = the entry has been written since reset.

Function
REQ-017 Access decode: the bus is active when Sel=0 and the strobe condition holds.
- BusMode=1: read = Rd_DS=0; write = Wr_RW=0.
- BusMode=0: Rd_DS=0 qualifies the cycle; Wr_RW=1 selects read, Wr_RW=0 selects write.
REQ-018 BusMode=1 with Rd_DS=0 and Wr_RW=0 at the same time: the access is ignored and no ack is issued.
REQ-019 The state machine has three states: IDLE, ACCESS and ACK.
REQ-020 IDLE to ACCESS: on the first edge that samples an active access; Addr, DataIn and the read/write direction are captured at that edge.
REQ-021 ACCESS to ACK: after exactly one cycle; the captured table operation is performed at this edge.
- Write: the table entry is updated and its valid bit is set.
- Read: DataOut is registered; an invalid entry reads as all-zero.
REQ-022 In ACK, Rdy_Dtack=0; it deasserts two edges after the request was sampled.
REQ-023 ACK to IDLE: on the first edge sampling Sel=1 or the strobe inactive; Rdy_Dtack=1 from that edge.
REQ-024 A new CPU access requires a return to IDLE; a held strobe never produces a second access.
REQ-025 DataOut holds the read value while in ACK and is zero in all other states.
REQ-026 Table: single-port; at most one operation (CPU or lookup) per cycle.
REQ-027 Arbitration: the CPU owns the port in the ACCESS cycle; a lookup is granted in any other cycle.
REQ-028 Lookup grant condition: lk_req=1, state is not ACCESS, and lk_ack=0 (this prevents double service of a held request).
REQ-029 Lookup latency: on a granted edge the entry is read; lk_ack=1 with lk_cfg/lk_hit in the following cycle only.
- Without conflict: 1 cycle.
- When blocked by ACCESS: 2 cycles.
REQ-030 A lookup granted after a CPU write's ACCESS edge returns the new data with lk_hit=1.
REQ-031 lk_cfg is zero when lk_ack=0 or lk_hit=0.
REQ-032 BusMode is sampled only in IDLE; a change during an access has no effect on that access.

Reset
REQ-033 While rst_n=0, immediately and without a clock, all of the following hold:
- state=IDLE, Rdy_Dtack=1, DataOut=0;
- lk_ack=0, lk_cfg=0, lk_hit=0;
- all valid bits cleared.
REQ-034 Table data contents are not reset; the cleared valid bits make every entry read as zero/miss.
REQ-035 Reset asserted mid-access aborts the access without writing the table; after release the block waits in IDLE for a new access.

Verification
REQ-036 Write then read (BusMode=1): write Addr=0x005 with FWD=4'b0101, VPI=0x0A5; ack is low 2 cycles after sampling; a read of 0x005 returns the same value with Rdy_Dtack=0.
REQ-037 BusMode=0 cycle: Rd_DS=0, Wr_RW=0 writes Addr=0xFFF; Rd_DS=0, Wr_RW=1 reads it back; Rdy_Dtack releases one edge after Sel returns to 1.
REQ-038 Lookup miss/hit: after reset, lk_vpi=0x005 gives lk_ack 1 cycle later with lk_hit=0, lk_cfg=0; after a CPU write to 0x005, lk_hit=1 with the written value.
REQ-039 Conflict: lk_req rises in the CPU ACCESS cycle; lk_ack arrives 2 cycles later; the CPU ack is not delayed.
REQ-040 Held request: lk_req held for 5 cycles with a constant lk_vpi produces lk_ack pulses no closer than every other cycle.
REQ-041 Reset mid-write: pull rst_n low in ACCESS; Rdy_Dtack=1 immediately, and a later read of that Addr returns 0.
